// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller: state encoding,
// instruction field layout and a decode helper.
package alu_issue_pkg;

   localparam int DATA_W  = 12;
   localparam int OP_W    = 3;
   localparam int RADDR_W = 3;
   localparam int NREGS   = 8;
   localparam int INSTR_W = 12;

   localparam int OP_LSB  = 9;
   localparam int RD_LSB  = 6;
   localparam int RS1_LSB = 3;
   localparam int RS2_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]    op;
      logic [RADDR_W-1:0] rd;
      logic [RADDR_W-1:0] rs1;
      logic [RADDR_W-1:0] rs2;
   } instr_t;

   function automatic instr_t decode(input logic [INSTR_W-1:0] w);
      instr_t d;
      d.op  = w[OP_LSB  +: OP_W];
      d.rd  = w[RD_LSB  +: RADDR_W];
      d.rs1 = w[RS1_LSB +: RADDR_W];
      d.rs2 = w[RS2_LSB +: RADDR_W];
      return d;
   endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x12 register file: two operand read ports, a debug read port and a single
// write port where the writeback path takes priority over an external load.
module alu_issue_regfile
   import alu_issue_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_wb_en,
   input  logic [RADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0]  i_wb_data,
   input  logic               i_ld_en,
   input  logic [RADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0]  i_ld_data,
   input  logic [RADDR_W-1:0] i_ra_addr,
   output logic [DATA_W-1:0]  o_ra_data,
   input  logic [RADDR_W-1:0] i_rb_addr,
   output logic [DATA_W-1:0]  o_rb_data,
   input  logic [RADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0]  o_dbg_data
);

   logic [DATA_W-1:0] r_mem [NREGS];

   assign o_ra_data  = r_mem[i_ra_addr];
   assign o_rb_data  = r_mem[i_rb_addr];
   assign o_dbg_data = r_mem[i_dbg_addr];

   // Per-entry write: a same-address load is dropped in favour of writeback
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_mem[i] <= {DATA_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i_wb_en && (i_wb_addr == RADDR_W'(i))) begin
               r_mem[i] <= i_wb_data;
            end else if (i_ld_en && (i_ld_addr == RADDR_W'(i))) begin
               r_mem[i] <= i_ld_data;
            end else begin
               r_mem[i] <= r_mem[i];
            end
         end
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Three-state issue controller: reads operands from the register file, drives
// an external combinational ALU, captures its result and writes it back.
module alu_issue
   import alu_issue_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   output logic [OP_W-1:0]    o_alu_op,
   output logic [DATA_W-1:0]  o_alu_op1,
   output logic [DATA_W-1:0]  o_alu_op2,
   input  logic [DATA_W-1:0]  i_alu_out,
   input  logic               i_ld_en,
   input  logic [RADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0]  i_ld_data,
   output logic               o_done,
   output logic [RADDR_W-1:0] o_done_rd,
   output logic [DATA_W-1:0]  o_done_data,
   input  logic [RADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0]  o_dbg_data
);

   state_t             r_state;
   logic [OP_W-1:0]    r_alu_op;
   logic [DATA_W-1:0]  r_alu_op1;
   logic [DATA_W-1:0]  r_alu_op2;
   logic [RADDR_W-1:0] r_rd;
   logic               r_done;
   logic [RADDR_W-1:0] r_done_rd;
   logic [DATA_W-1:0]  r_done_data;

   instr_t             w_dec;
   logic [DATA_W-1:0]  w_rs1_data;
   logic [DATA_W-1:0]  w_rs2_data;
   logic               w_wb_en;

   assign w_dec         = decode(i_instr);
   assign w_wb_en       = (r_state == ST_WB);
   assign o_instr_ready = (r_state == ST_IDLE);

   assign o_alu_op    = r_alu_op;
   assign o_alu_op1   = r_alu_op1;
   assign o_alu_op2   = r_alu_op2;
   assign o_done      = r_done;
   assign o_done_rd   = r_done_rd;
   assign o_done_data = r_done_data;

   alu_issue_regfile u_regfile (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wb_en    (w_wb_en),
      .i_wb_addr  (r_done_rd),
      .i_wb_data  (r_done_data),
      .i_ld_en    (i_ld_en),
      .i_ld_addr  (i_ld_addr),
      .i_ld_data  (i_ld_data),
      .i_ra_addr  (w_dec.rs1),
      .o_ra_data  (w_rs1_data),
      .i_rb_addr  (w_dec.rs2),
      .o_rb_data  (w_rs2_data),
      .i_dbg_addr (i_dbg_addr),
      .o_dbg_data (o_dbg_data)
   );

   // Issue FSM; the result register doubles as the writeback data and done_data
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_alu_op    <= {OP_W{1'b0}};
         r_alu_op1   <= {DATA_W{1'b0}};
         r_alu_op2   <= {DATA_W{1'b0}};
         r_rd        <= {RADDR_W{1'b0}};
         r_done      <= 1'b0;
         r_done_rd   <= {RADDR_W{1'b0}};
         r_done_data <= {DATA_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_instr_valid) begin
                  r_alu_op  <= w_dec.op;
                  r_alu_op1 <= w_rs1_data;
                  r_alu_op2 <= w_rs2_data;
                  r_rd      <= w_dec.rd;
                  r_state   <= ST_EXEC;
               end else begin
                  r_state   <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               r_done_data <= i_alu_out;
               r_done_rd   <= r_rd;
               r_done      <= 1'b1;
               r_state     <= ST_WB;
            end
            ST_WB: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue with a stub ALU (op1 + op2 + op, mod 4096):
// a cycle-scheduled reference model plus directed hand-computed checks.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [2:0]  alu_op;
   logic [11:0] alu_op1;
   logic [11:0] alu_op2;
   logic [11:0] alu_out;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [11:0] ld_data;
   logic        done;
   logic [2:0]  done_rd;
   logic [11:0] done_data;
   logic [2:0]  dbg_addr;
   logic [11:0] dbg_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign alu_out = alu_op1 + alu_op2 + {9'd0, alu_op};

   alu_issue dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_instr       (instr),
      .i_instr_valid (instr_valid),
      .o_instr_ready (instr_ready),
      .o_alu_op      (alu_op),
      .o_alu_op1     (alu_op1),
      .o_alu_op2     (alu_op2),
      .i_alu_out     (alu_out),
      .i_ld_en       (ld_en),
      .i_ld_addr     (ld_addr),
      .i_ld_data     (ld_data),
      .o_done        (done),
      .o_done_rd     (done_rd),
      .o_done_data   (done_data),
      .i_dbg_addr    (dbg_addr),
      .o_dbg_data    (dbg_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: register array plus a schedule keyed on the accept edge
   logic [11:0] m_rf [8];
   logic        m_pend;
   int          m_acc;
   int          cyc = 0;
   int          e;
   logic        m_was_ready;
   logic        m_accept;
   logic [2:0]  m_op;
   logic [2:0]  m_rd;
   logic [11:0] m_op1;
   logic [11:0] m_op2;
   logic [11:0] m_res;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) m_rf[i] = 12'h000;
         m_pend = 1'b0;
         m_acc  = -10;
         m_op   = 3'd0;
         m_rd   = 3'd0;
         m_op1  = 12'h000;
         m_op2  = 12'h000;
         m_res  = 12'h000;
      end else begin
         e           = cyc + 1;
         m_was_ready = !m_pend;
         m_accept    = m_was_ready && instr_valid;
         if (m_accept) begin
            m_op  = instr[11:9];
            m_rd  = instr[8:6];
            m_op1 = m_rf[instr[5:3]];
            m_op2 = m_rf[instr[2:0]];
            m_res = 12'((m_op1 + m_op2 + {9'd0, m_op}) % 4096);
         end
         if (m_pend && e == m_acc + 2) begin
            m_rf[m_rd] = m_res;
            if (ld_en && ld_addr != m_rd) m_rf[ld_addr] = ld_data;
            m_pend = 1'b0;
         end else if (ld_en) begin
            m_rf[ld_addr] = ld_data;
         end
         if (m_accept) begin
            m_pend = 1'b1;
            m_acc  = e;
         end
         cyc = e;
      end
   end

   // Per-cycle comparison against the model
   logic exp_done;
   always @(negedge clk) begin
      exp_done = m_pend && (cyc == m_acc + 1);
      chk("m_ready",    instr_ready, !m_pend);
      chk("m_done",     done,        exp_done);
      chk("m_alu_op",   alu_op,      m_op);
      chk("m_alu_op1",  alu_op1,     m_op1);
      chk("m_alu_op2",  alu_op2,     m_op2);
      chk("m_dbg_data", dbg_data,    m_rf[dbg_addr]);
      if (exp_done) begin
         chk("m_done_rd",   done_rd,   m_rd);
         chk("m_done_data", done_data, m_res);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] a, input logic [11:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_en = 1'b0;
   endtask

   task automatic read_rf(input logic [2:0] a, input logic [11:0] exp, input string nm);
      dbg_addr = a;
      #1;
      chk(nm, dbg_data, exp);
   endtask

   // Presents an instruction and returns just after its accept edge (EXEC)
   task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2);
      int n;
      n = 0;
      instr = {op, rd, rs1, rs2};
      instr_valid = 1'b1;
      while (!instr_ready && n < 10) begin
         tick();
         n++;
      end
      chk("issue_ready_bound", instr_ready, 1'b1);
      tick();
      instr_valid = 1'b0;
   endtask

   int acc1, acc2;

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; instr = 12'h000; instr_valid = 1'b0;
      ld_en = 1'b0; ld_addr = 3'd0; ld_data = 12'h000; dbg_addr = 3'd0;
      #2 rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_done_rd", done_rd, 3'd0);
      chk("rst_done_data", done_data, 12'h000);
      chk("rst_alu_op1", alu_op1, 12'h000);
      for (int i = 0; i < 8; i++) read_rf(3'(i), 12'h000, "rst_rf");

      // Basic instruction: R3 = 0x00F + 0x003 + 1
      load(3'd1, 12'h00F);
      load(3'd2, 12'h003);
      issue(3'b001, 3'd3, 3'd1, 3'd2);
      chk("t2_exec_done", done, 1'b0);
      chk("t2_exec_ready", instr_ready, 1'b0);
      chk("t2_op1", alu_op1, 12'h00F);
      chk("t2_op2", alu_op2, 12'h003);
      tick();
      chk("t2_done", done, 1'b1);
      chk("t2_done_rd", done_rd, 3'd3);
      chk("t2_done_data", done_data, 12'h013);
      tick();
      chk("t2_done_clr", done, 1'b0);
      read_rf(3'd3, 12'h013, "t2_r3");

      // Back-to-back with instr_valid held: accepts spaced 3 cycles apart
      instr = {3'b010, 3'd5, 3'd1, 3'd2};
      instr_valid = 1'b1;
      acc1 = -1; acc2 = -1;
      for (int k = 0; k < 10; k++) begin
         if (instr_ready) begin
            if (acc1 < 0) acc1 = k;
            else if (acc2 < 0) acc2 = k;
         end
         if (k == 1 || k == 2) chk("t3_ready_low", instr_ready, 1'b0);
         tick();
      end
      instr_valid = 1'b0;
      chk("t3_spacing", acc2 - acc1, 3);
      tick();
      tick();
      read_rf(3'd5, 12'h014, "t3_r5");

      // Load into rs1 during the accept cycle: old value is used
      chk("t_ldacc_idle", instr_ready, 1'b1);
      instr = {3'd0, 3'd6, 3'd1, 3'd2};
      instr_valid = 1'b1;
      ld_en = 1'b1; ld_addr = 3'd1; ld_data = 12'h100;
      tick();
      instr_valid = 1'b0; ld_en = 1'b0;
      chk("t_ldacc_op1", alu_op1, 12'h00F);
      read_rf(3'd1, 12'h100, "t_ldacc_r1");
      tick();
      chk("t_ldacc_res", done_data, 12'h012);
      tick();

      // Wrap-around with rd == rs1 == rs2
      load(3'd1, 12'hFFF);
      load(3'd2, 12'h001);
      issue(3'b000, 3'd1, 3'd1, 3'd1);
      chk("t4_op1", alu_op1, 12'hFFF);
      chk("t4_op2", alu_op2, 12'hFFF);
      tick();
      chk("t4_done_data", done_data, 12'hFFE);
      tick();
      chk("t4_op1_held", alu_op1, 12'hFFF);
      chk("t4_op2_held", alu_op2, 12'hFFF);
      read_rf(3'd1, 12'hFFE, "t4_r1");

      // Writeback beats a same-address load in the WB cycle
      load(3'd1, 12'h00F);
      load(3'd2, 12'h003);
      load(3'd3, 12'h000);
      issue(3'b001, 3'd3, 3'd1, 3'd2);
      tick();
      chk("t5_wb_cycle", done, 1'b1);
      ld_en = 1'b1; ld_addr = 3'd3; ld_data = 12'h0AA;
      tick();
      ld_en = 1'b0;
      read_rf(3'd3, 12'h013, "t5_r3_wb_wins");

      // Different addresses: both writes land
      load(3'd3, 12'h000);
      issue(3'b001, 3'd3, 3'd1, 3'd2);
      tick();
      ld_en = 1'b1; ld_addr = 3'd4; ld_data = 12'h0AA;
      tick();
      ld_en = 1'b0;
      read_rf(3'd3, 12'h013, "t5_r3_both");
      read_rf(3'd4, 12'h0AA, "t5_r4_both");

      // Reset during EXEC aborts the instruction
      issue(3'b001, 3'd7, 3'd1, 3'd2);
      rst = 1'b1;
      #1;
      chk("t6_done", done, 1'b0);
      chk("t6_op", alu_op, 3'd0);
      chk("t6_op1", alu_op1, 12'h000);
      chk("t6_op2", alu_op2, 12'h000);
      chk("t6_ready", instr_ready, 1'b1);
      for (int i = 0; i < 8; i++) read_rf(3'(i), 12'h000, "t6_rf");
      tick();
      rst = 1'b0;
      repeat (3) begin
         tick();
         chk("t6_no_done", done, 1'b0);
      end
      read_rf(3'd7, 12'h000, "t6_r7");
      load(3'd1, 12'h020);
      load(3'd2, 12'h005);
      issue(3'b010, 3'd7, 3'd1, 3'd2);
      tick();
      chk("t6_next_done", done, 1'b1);
      chk("t6_next_data", done_data, 12'h027);
      tick();
      read_rf(3'd7, 12'h027, "t6_next_r7");

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
